// File: rtl/tdm_demux8.sv
// Serial-to-parallel TDM demultiplexer: slot k of each sync-marked frame lands in y[k].
// Presents completed words with a valid pulse, flags mid-frame sync, counts good frames.
module tdm_demux8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             sync,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic [SEL_W-1:0] slot,
    output logic             busy,
    output logic             sync_err,
    output logic [7:0]       frame_cnt
);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] ONE       = SEL_W'(1);

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_sh, w_sh_nx;
    logic [WIDTH-1:0] r_y, w_y_nx;
    logic [SEL_W-1:0] r_slot, w_slot_nx;
    logic             r_valid, w_valid_nx;
    logic             r_serr, w_serr_nx;
    logic [7:0]       r_cnt, w_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_y     <= '0;
            r_slot  <= '0;
            r_valid <= 1'b0;
            r_serr  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sh    <= w_sh_nx;
            r_y     <= w_y_nx;
            r_slot  <= w_slot_nx;
            r_valid <= w_valid_nx;
            r_serr  <= w_serr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sh_nx    = r_sh;
        w_y_nx     = r_y;
        w_slot_nx  = r_slot;
        w_valid_nx = 1'b0;
        w_serr_nx  = 1'b0;
        w_cnt_nx   = r_cnt;
        case (r_state)
            IDLE: begin
                // Unsynced strobes are dropped; only a sync-marked bit opens a frame.
                if (en && sync) begin
                    w_sh_nx[0] = din;
                    w_slot_nx  = ONE;
                    w_state_nx = RECV;
                end
            end
            RECV: begin
                if (en) begin
                    if (sync) begin
                        // Realign: the sync bit becomes slot 0 of a fresh frame.
                        w_serr_nx  = 1'b1;
                        w_sh_nx[0] = din;
                        w_slot_nx  = ONE;
                    end else if (r_slot == LAST_SLOT) begin
                        w_y_nx     = {din, r_sh[WIDTH-2:0]};
                        w_valid_nx = 1'b1;
                        w_cnt_nx   = r_cnt + 8'd1;
                        w_slot_nx  = '0;
                        w_state_nx = IDLE;
                    end else begin
                        w_sh_nx[r_slot] = din;
                        w_slot_nx       = r_slot + ONE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign y         = r_y;
    assign valid     = r_valid;
    assign slot      = r_slot;
    assign busy      = (r_state == RECV);
    assign sync_err  = r_serr;
    assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: hand-computed frames, gaps, realign, noise, reset, wrap.
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] y;
    logic       valid;
    logic [2:0] slot;
    logic       busy;
    logic       sync_err;
    logic [7:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int vcnt  = 0;

    tdm_demux8 #(.WIDTH(8), .SEL_W(3)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .y(y), .valid(valid), .slot(slot), .busy(busy),
        .sync_err(sync_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // valid lasts a full cycle, so one negedge sample per pulse
    always @(negedge clk) if (valid === 1'b1) vcnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b, input logic s);
        @(negedge clk);
        en = 1'b1; din = b; sync = s;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b0; sync = 1'b0; din = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; sync = 1'b1; din = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;
    endtask

    // gap_at: insert two idle cycles before that slot (-1 for none)
    task automatic send_frame(input logic [7:0] v, input int gap_at);
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                idle(2);
                chk("gap_slot", {29'd0, slot}, k);
                chk("gap_busy", busy, 1);
            end
            strobe(v[k], k == 0);
        end
    endtask

    logic [7:0] f;
    int v0;

    initial begin
        // reset held 3 cycles with en/sync/din high
        @(negedge clk);
        rst = 1'b1; en = 1'b1; sync = 1'b1; din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_out", {y, valid, slot, busy, sync_err, frame_cnt}, 0);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; sync = 1'b0; din = 1'b0;
        @(posedge clk); #1;
        chk("rst_after", {y, valid, slot, busy, sync_err, frame_cnt}, 0);
        idle(1);

        // single frame 0x96
        v0 = vcnt;
        send_frame(8'h96, -1);
        chk("f96_y", y, 8'h96);
        chk("f96_valid", valid, 1);
        chk("f96_cnt", frame_cnt, 1);
        chk("f96_busy", busy, 0);
        chk("f96_slot", {29'd0, slot}, 0);
        idle(1);
        chk("f96_valid_drop", valid, 0);
        chk("f96_pulses", vcnt - v0, 1);

        // 0x71 with a gap between slots 3 and 4, then 0x96 back-to-back
        v0 = vcnt;
        send_frame(8'h71, 4);
        chk("f71_y", y, 8'h71);
        chk("f71_cnt", frame_cnt, 2);
        send_frame(8'h96, -1);
        chk("b2b_y", y, 8'h96);
        chk("b2b_cnt", frame_cnt, 3);
        idle(1);
        chk("b2b_pulses", vcnt - v0, 2);

        // realign at slot 5; new frame 0x3C begins at the sync bit
        v0 = vcnt;
        f = 8'hFF;
        for (int k = 0; k < 5; k++) strobe(f[k], k == 0);
        f = 8'h3C;
        strobe(f[0], 1'b1);
        chk("realign_err", sync_err, 1);
        chk("realign_valid", valid, 0);
        chk("realign_y", y, 8'h96);
        chk("realign_slot", {29'd0, slot}, 1);
        chk("realign_busy", busy, 1);
        for (int k = 1; k < 8; k++) begin
            strobe(f[k], 1'b0);
            if (k == 1) chk("realign_err_drop", sync_err, 0);
        end
        chk("realign_y_new", y, 8'h3C);
        chk("realign_cnt", frame_cnt, 4);
        idle(1);
        chk("realign_pulses", vcnt - v0, 1);

        // 20 unsynced strobes from IDLE
        v0 = vcnt;
        for (int i = 0; i < 20; i++) strobe(i[0], 1'b0);
        chk("noise_slot", {29'd0, slot}, 0);
        chk("noise_busy", busy, 0);
        chk("noise_cnt", frame_cnt, 4);
        idle(1);
        chk("noise_pulses", vcnt - v0, 0);

        // reset at slot 4, then 0xA5
        f = 8'h5A;
        for (int k = 0; k < 4; k++) strobe(f[k], k == 0);
        pulse_rst();
        chk("midrst_y", y, 0);
        chk("midrst_busy", busy, 0);
        v0 = vcnt;
        send_frame(8'hA5, -1);
        chk("a5_y", y, 8'hA5);
        chk("a5_cnt", frame_cnt, 1);
        idle(1);
        chk("a5_pulses", vcnt - v0, 1);

        // 256 good frames from a fresh reset wraps the counter to 0
        pulse_rst();
        for (int i = 0; i < 256; i++) begin
            f = i[7:0];
            send_frame(f, -1);
            if (i == 254) chk("wrap_255", frame_cnt, 255);
        end
        chk("wrap_0", frame_cnt, 0);
        chk("wrap_y", y, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
